serial_load_ctrl: RTL

SERIAL_LOAD_CTRL -- requirements
Module: serial_load_ctrl

---
 rtl/serial_pkg.sv | 17 +
 rtl/bit_counter.sv | 24 ++
 rtl/serial_load_ctrl.sv | 80 ++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared types and constants for the serial frame load controller.
package serial_pkg;

    // Controller states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HUNT  = 3'd1,
        SHIFT = 3'd2,
        STOP  = 3'd3,
        VALID = 3'd4
    } state_t;

    // Default data bits per frame and width of the bit counter output
    localparam int NBITS_DEF = 4;
    localparam int CNT_W     = 4;

endpackage

// File: rtl/bit_counter.sv
// Saturating up-counter: synchronous clear has priority over enable,
// and the count sticks at N once reached.
module bit_counter #(
    parameter int N = 4,
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         en,
    output logic [W-1:0] count
);

    // Count enabled cycles, clear on request, never wrap past N
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (en && (count != W'(N)))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/serial_load_ctrl.sv
// Frame controller for an external shift register: hunts for a start bit,
// pulses the shift enable once per data bit, checks the stop bit and holds
// the word valid until the consumer acknowledges it.
module serial_load_ctrl
    import serial_pkg::*;
#(
    parameter int NBITS = NBITS_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clkEN,
    input  logic             start,
    input  logic             SerIn,
    input  logic             ack,
    output logic             sh_enD,
    output logic             busy,
    output logic             data_valid,
    output logic             frame_err,
    output logic [CNT_W-1:0] bit_cnt
);

    state_t state;
    logic   cnt_clr;
    logic   at_last;

    // Shift enable is combinational so the shifter samples SerIn on the
    // same edge the FSM advances; gated by reset so it is low during reset.
    assign sh_enD  = reset && (state == SHIFT) && clkEN;
    // Counter clears on the start-bit tick, i.e. on entry to SHIFT
    assign cnt_clr = (state == HUNT) && clkEN && !SerIn;
    // Last data bit is being shifted on this tick
    assign at_last = (bit_cnt == CNT_W'(NBITS - 1));
    assign busy    = (state != IDLE);

    bit_counter #(
        .N (NBITS),
        .W (CNT_W)
    ) u_cnt (
        .clock (clock),
        .reset (reset),
        .clear (cnt_clr),
        .en    (sh_enD),
        .count (bit_cnt)
    );

    // Frame sequencing with registered data_valid and one-cycle frame_err
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                IDLE:  if (start) state <= HUNT;
                HUNT:  if (clkEN && !SerIn) state <= SHIFT;
                SHIFT: if (clkEN && at_last) state <= STOP;
                STOP: begin
                    if (clkEN) begin
                        if (SerIn) begin
                            state      <= VALID;
                            data_valid <= 1'b1;
                        end else begin
                            state     <= IDLE;
                            frame_err <= 1'b1;
                        end
                    end
                end
                VALID: begin
                    if (ack) begin
                        state      <= IDLE;
                        data_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
